pc_fetch_gen: RTL
=================

// Module: pc_fetch_gen
// PURPOSE
//  Parametrised program-counter generator for the IF stage; next generation of the simple PC register/counter.
//  Holds the fetch PC and issues it to instruction memory over a req/gnt handshake.
//  Selects the next PC by fixed priority: trap redirect, EX-stage redirect, BTB prediction, then sequential PC+4.
//  Handles stalls from the hazard unit and reports misaligned redirect targets.
// PARAMETERS
//  XLEN         32            PC / address width in bits (>= 8)
//  RESET_VEC    32'h0000_0000 PC value loaded on reset; bits [1:0] must be 0
//  BTB_ENTRIES  8             direct-mapped BTB depth, power of 2 >= 2 (used only with PC_BTB_EN)
// PORTS
//  clk              in   1     clock, rising edge
//  rst_n            in   1     asynchronous reset, active-low
//  stall_i          in   1     hazard-unit stall: hold PC (redirects still win)
//  trap_redirect_i  in   1     trap/exception redirect request
//  trap_target_i    in   XLEN  trap handler address
//  ex_redirect_i    in   1     EX-stage branch/jump redirect (mispredict or taken)
//  ex_target_i      in   XLEN  EX redirect target
//  btb_upd_i        in   1     BTB write strobe from EX (resolved taken branch)
//  btb_upd_pc_i     in   XLEN  PC of the resolved branch
//  btb_upd_tgt_i    in   XLEN  resolved target
//  imem_gnt_i       in   1     instruction memory accepts current request
//  imem_req_o       out  1     fetch request valid
//  imem_addr_o      out  XLEN  fetch address (== pc_o)
//  pc_o             out  XLEN  current fetch PC
//  pc_plus4_o       out  XLEN  pc_o + 4, modulo 2^XLEN (combinational)
//  pred_taken_o     out  1     current pc_o was reached by a BTB prediction
//  misalign_o       out  1     one-cycle pulse: accepted redirect target had bits [1:0] != 0
// BEHAVIOUR
//  Reset: pc_o=RESET_VEC, imem_req_o=0, pred_taken_o=0, misalign_o=0, state=BOOT; BTB valid bits cleared.
//  FSM states:
//   BOOT   -> FETCH after one cycle; no request is issued in BOOT.
//   FETCH  imem_req_o=1. fire = imem_gnt_i & ~stall_i advances to next PC.
//          Goes to HOLD if the request is pending (~imem_gnt_i) or stall_i is high.
//   HOLD   imem_req_o=1 with pc_o unchanged (request stays stable until granted).
//          Returns to FETCH when fire occurs.
//  Next PC, registered, taking effect one cycle after the condition:
//   1. trap_redirect_i: pc <= {trap_target_i[XLEN-1:2],2'b00}. Ignores stall_i and gnt; state -> FETCH.
//   2. else ex_redirect_i: pc <= {ex_target_i[XLEN-1:2],2'b00}. Ignores stall_i and gnt; state -> FETCH.
//   3. else fire & BTB hit: pc <= BTB target; pred_taken_o <= 1.
//   4. else fire: pc <= pc + 4 (0xFFFF_FFFC wraps to 0); pred_taken_o <= 0.
//   5. else: hold all state.
//  Both redirects asserted in the same cycle: trap wins and the EX redirect is dropped.
//  misalign_o <= 1 for exactly one cycle when the winning redirect target has [1:0] != 0.
//  A redirect during BOOT is accepted and skips the rest of BOOT.
//  Reset asserted mid-operation forces the reset values immediately (asynchronous); no request glitch after release.
// CONFIGURATION
//  PC_BTB_EN defined:
//   BTB is direct-mapped; index = pc[IDX+1:2] with IDX=$clog2(BTB_ENTRIES); tag = pc[XLEN-1:IDX+2].
//   Entry = valid + tag + target.
//   btb_upd_i writes an entry on the clock edge; a write and a lookup of the same index in one cycle return the old entry.
//   BTB targets are stored with [1:0] forced to 0.
//  PC_BTB_EN undefined:
//   No BTB storage; btb_upd_* inputs are ignored; pred_taken_o tied to 0.
//   Next-PC priority reduces to steps 1, 2, 4, 5.
// STRUCTURE
//  Shared package pc_pkg:
//   state enum (BOOT, FETCH, HOLD).
//   PC_INC=4.
//   align_word() helper that clears bits [1:0].
//  Sub-module pc_btb (lookup/update array), instantiated only under PC_BTB_EN.
// TESTING
//  Reset, then gnt=1 with no stall:
//   pc_o = 0 during BOOT, then 0, 4, 8, 0xC...; imem_req_o is 0 in the first cycle only.
//  stall_i=1 for 3 cycles at pc=0x10:
//   pc_o holds 0x10 with imem_req_o=1; pc 0x14 appears one cycle after stall_i drops.
//  gnt=0 for 2 cycles at pc=0x20, with ex_redirect_i=1 and target 0x103 in the second cycle:
//   next pc_o=0x100; misalign_o pulses once.
//  trap_redirect_i with target 0x80 and ex_redirect_i with target 0x200 in the same cycle:
//   pc_o=0x80; the EX redirect is lost.
//  Force pc=0xFFFF_FFFC (via redirect) then fire: pc_o=0, pc_plus4_o=4.
//  PC_BTB_EN, btb_upd_i with pc=0x40 and target 0x400, then sequential fetch reaches 0x40:
//   next pc_o=0x400 with pred_taken_o=1; without the macro, pc_o=0x44.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the IF-stage program-counter generator:
// fetch FSM state encoding, the sequential PC increment and word alignment.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } pc_state_e;

    // Byte distance between consecutive 32-bit instructions.
    localparam int PC_INC = 4;

    // Widest address the alignment helper handles; callers cast to/from XLEN.
    localparam int PC_MAX_W = 64;

    // Forces an address onto a 4-byte instruction boundary.
    function automatic logic [PC_MAX_W-1:0] align_word(input logic [PC_MAX_W-1:0] addr);
        return {addr[PC_MAX_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer used by pc_fetch_gen when PC_BTB_EN is
// defined. Index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2]. Lookup is
// combinational from the stored array, so an update and a lookup of the same
// index in one cycle return the entry as it was before the clock edge.
module pc_btb
    import pc_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            hit_o,
    output logic [XLEN-1:0] target_o,
    input  logic            upd_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic [XLEN-1:0] upd_tgt_i
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];

    logic [IDX-1:0]   rd_idx;
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = lookup_pc_i[IDX+1:2];
    assign rd_tag = lookup_pc_i[XLEN-1:IDX+2];
    assign wr_idx = upd_pc_i[IDX+1:2];
    assign wr_tag = upd_pc_i[XLEN-1:IDX+2];

    // Valid bits are the only BTB state that must be cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (upd_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and target payload; meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (upd_i) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= XLEN'(align_word(PC_MAX_W'(upd_tgt_i)));
        end
    end

    assign hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign target_o = tgt_q[rd_idx];

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_lsb;
    assign unused_lsb = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

endmodule

// File: rtl/pc_fetch_gen.sv
// IF-stage program-counter generator. Holds the fetch PC, issues it to
// instruction memory over req/gnt, and picks the next PC by priority:
// trap redirect, EX redirect, BTB prediction, sequential PC+4.
// Build option: define PC_BTB_EN to include the branch target buffer
// (pc_btb); without it the btb_upd_* inputs are ignored and pred_taken_o
// stays 0.
module pc_fetch_gen
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            trap_redirect_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            ex_redirect_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            btb_upd_i,
    input  logic [XLEN-1:0] btb_upd_pc_i,
    input  logic [XLEN-1:0] btb_upd_tgt_i,
    input  logic            imem_gnt_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            pred_taken_o,
    output logic            misalign_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pred_q, pred_d;
    logic            mis_q, mis_d;

    logic            req;
    logic            fire;
    logic            btb_hit;
    logic [XLEN-1:0] btb_tgt;

`ifdef PC_BTB_EN
    pc_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_pc_i (pc_q),
        .hit_o       (btb_hit),
        .target_o    (btb_tgt),
        .upd_i       (btb_upd_i),
        .upd_pc_i    (btb_upd_pc_i),
        .upd_tgt_i   (btb_upd_tgt_i)
    );
`else
    assign btb_hit = 1'b0;
    assign btb_tgt = '0;

    // Without a BTB the update port and its depth have no consumer.
    logic unused_btb;
    assign unused_btb = ^{btb_upd_i, btb_upd_pc_i, btb_upd_tgt_i, 1'(BTB_ENTRIES)};
`endif

    // No request goes out while booting; afterwards it is held until granted.
    assign req  = (state_q != BOOT);
    assign fire = req & imem_gnt_i & ~stall_i;

    // Next-state and next-PC selection; redirects override stall and grant.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pred_d  = pred_q;
        mis_d   = 1'b0;

        unique case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = fire ? FETCH : HOLD;
            HOLD:    state_d = fire ? FETCH : HOLD;
            default: state_d = BOOT;
        endcase

        if (trap_redirect_i) begin
            pc_d    = XLEN'(align_word(PC_MAX_W'(trap_target_i)));
            pred_d  = 1'b0;
            mis_d   = |trap_target_i[1:0];
            state_d = FETCH;
        end else if (ex_redirect_i) begin
            pc_d    = XLEN'(align_word(PC_MAX_W'(ex_target_i)));
            pred_d  = 1'b0;
            mis_d   = |ex_target_i[1:0];
            state_d = FETCH;
        end else if (fire && btb_hit) begin
            pc_d   = btb_tgt;
            pred_d = 1'b1;
        end else if (fire) begin
            pc_d   = pc_q + XLEN'(PC_INC);
            pred_d = 1'b0;
        end
    end

    // Architectural fetch state; reset drops the request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            pred_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pred_q  <= pred_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_req_o   = req;
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign pc_plus4_o   = pc_q + XLEN'(PC_INC);
    assign pred_taken_o = pred_q;
    assign misalign_o   = mis_q;

endmodule
